// File: rtl/ttt_turn_scheduler.sv
// Turn sequencer and board write arbiter for the tic-tac-toe datapath.
// Optional player move timeout enabled by defining TTT_TIMEOUT_EN.
module ttt_turn_scheduler #(
    parameter int FIRST_MOVER = 0,
    parameter int SCORE_W     = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               plyr_req,
    input  logic [3:0]         plyr_pos,
    output logic               plyr_ack,
    input  logic               comp_req,
    input  logic [3:0]         comp_pos,
    output logic               comp_ack,
    output logic               move_rej,
    input  logic               illegal_move,
    input  logic               win,
    input  logic [1:0]         who,
    input  logic               no_space,
    output logic               board_clr,
    output logic [8:0]         pl_en,
    output logic [8:0]         pc_en,
    output logic               turn,
    output logic               game_over,
    output logic [1:0]         result,
    output logic [SCORE_W-1:0] plyr_score,
    output logic [SCORE_W-1:0] comp_score,
`ifdef TTT_TIMEOUT_EN
    output logic               timeout,
`endif
    output logic [SCORE_W-1:0] draw_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_OVER   = 3'd5;

    localparam logic FM = (FIRST_MOVER != 0);

    logic [2:0] state;
    logic [3:0] pos_q;
    logic       commit;
    logic       pos_ok;
    logic [8:0] hot;
    logic       honour;
    logic       tmo_hit;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    assign commit    = (state == S_COMMIT);
    assign pos_ok    = (pos_q <= 4'd8);
    assign hot       = pos_ok ? (9'd1 << pos_q) : 9'd0;
    assign honour    = turn ? comp_req : plyr_req;
    assign plyr_ack  = commit & ~turn;
    assign comp_ack  = commit & turn;
    assign move_rej  = commit & (~pos_ok | illegal_move);
    assign pl_en     = (commit && !turn) ? hot : 9'd0;
    assign pc_en     = (commit && turn) ? hot : 9'd0;
    assign board_clr = (state == S_CLEAR);
    assign game_over = (state == S_OVER);

`ifdef TTT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == S_WAIT) && !turn && !plyr_req
                   && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign timeout = tmo_hit;

    // Counter only runs while the player owns the turn in WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == S_WAIT && !turn && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    wire unused_tmo = (TIMEOUT_CYC > 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pos_q      <= 4'd0;
            turn       <= FM;
            result     <= 2'b00;
            plyr_score <= '0;
            comp_score <= '0;
            draw_cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) state <= S_CLEAR;
                end
                S_CLEAR: begin
                    result <= 2'b00;
                    turn   <= FM;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (honour) begin
                        pos_q <= turn ? comp_pos : plyr_pos;
                        state <= S_COMMIT;
                    end else if (tmo_hit) begin
                        turn <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    state <= move_rej ? S_WAIT : S_CHECK;
                end
                S_CHECK: begin
                    if (win) begin
                        result <= who;
                        if (who == 2'b01) plyr_score <= sat_inc(plyr_score);
                        if (who == 2'b10) comp_score <= sat_inc(comp_score);
                        state <= S_OVER;
                    end else if (no_space) begin
                        result   <= 2'b11;
                        draw_cnt <= sat_inc(draw_cnt);
                        state    <= S_OVER;
                    end else begin
                        turn  <= ~turn;
                        state <= S_WAIT;
                    end
                end
                S_OVER: begin
                    if (start) state <= S_CLEAR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_turn_scheduler.sv
// Randomized bench for ttt_turn_scheduler; the bench plays the board datapath.
module tb_ttt_turn_scheduler;

    localparam int SW   = 2;
    localparam int SMAX = 3;

    logic          clk = 0;
    logic          reset;
    logic          start;
    logic          plyr_req;
    logic [3:0]    plyr_pos;
    logic          plyr_ack;
    logic          comp_req;
    logic [3:0]    comp_pos;
    logic          comp_ack;
    logic          move_rej;
    logic          illegal_move;
    logic          win;
    logic [1:0]    who;
    logic          no_space;
    logic          board_clr;
    logic [8:0]    pl_en;
    logic [8:0]    pc_en;
    logic          turn;
    logic          game_over;
    logic [1:0]    result;
    logic [SW-1:0] plyr_score;
    logic [SW-1:0] comp_score;
    logic [SW-1:0] draw_cnt;
`ifdef TTT_TIMEOUT_EN
    logic          timeout;
`endif

    ttt_turn_scheduler #(
        .FIRST_MOVER(0),
        .SCORE_W(SW),
        .TIMEOUT_CYC(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .plyr_req(plyr_req),
        .plyr_pos(plyr_pos),
        .plyr_ack(plyr_ack),
        .comp_req(comp_req),
        .comp_pos(comp_pos),
        .comp_ack(comp_ack),
        .move_rej(move_rej),
        .illegal_move(illegal_move),
        .win(win),
        .who(who),
        .no_space(no_space),
        .board_clr(board_clr),
        .pl_en(pl_en),
        .pc_en(pc_en),
        .turn(turn),
        .game_over(game_over),
        .result(result),
        .plyr_score(plyr_score),
        .comp_score(comp_score),
`ifdef TTT_TIMEOUT_EN
        .timeout(timeout),
`endif
        .draw_cnt(draw_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: board contents 0 empty, 1 player, 2 computer
    int mb[9];
    bit mturn;
    bit mover;
    int mres;
    int ps, cs, dc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner();
        int l[24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};
        for (int i = 0; i < 8; i++) begin
            if (mb[l[3*i]] != 0 && mb[l[3*i]] == mb[l[3*i+1]]
                && mb[l[3*i]] == mb[l[3*i+2]])
                return mb[l[3*i]];
        end
        return 0;
    endfunction

    function automatic bit full();
        for (int i = 0; i < 9; i++) if (mb[i] == 0) return 0;
        return 1;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_turn"}, turn, mturn);
        chk({tag, "_over"}, game_over, mover);
        chk({tag, "_res"}, result, mres);
        chk({tag, "_ps"}, plyr_score, ps);
        chk({tag, "_cs"}, comp_score, cs);
        chk({tag, "_dc"}, draw_cnt, dc);
    endtask

    // entered at posedge+1 with the DUT in IDLE or OVER
    task automatic start_game();
        start = 1;
        @(negedge clk);
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("clr_on", board_clr, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) mb[i] = 0;
        mres  = 0;
        mturn = 0;
        mover = 0;
        @(negedge clk);
        chk("clr_off", board_clr, 0);
        check_state("start");
        @(posedge clk); #1;
    endtask

    // entered at posedge+1 with the DUT in WAIT or OVER; leaves the same way
    task automatic move(input bit side, input int pos);
        bit hon, ill, rej;
        int w;
        logic [8:0] hot;
        hon = !mover && (side == mturn);
        ill = (pos < 9) && (mb[pos] != 0);
        rej = (pos > 8) || ill;
        hot = (pos < 9) ? (9'd1 << pos) : 9'd0;
        if (side) begin
            comp_req = 1;
            comp_pos = pos[3:0];
        end else begin
            plyr_req = 1;
            plyr_pos = pos[3:0];
        end
        illegal_move = ill;
        @(negedge clk);
        chk("ack_early", {plyr_ack, comp_ack}, 0);
        @(negedge clk);
        chk("plyr_ack", plyr_ack, hon && !side);
        chk("comp_ack", comp_ack, hon && side);
        if (hon) chk("move_rej", move_rej, rej);
        chk("pl_en", pl_en, (hon && !side) ? hot : 9'd0);
        chk("pc_en", pc_en, (hon && side) ? hot : 9'd0);
        @(posedge clk); #1;
        plyr_req = 0;
        comp_req = 0;
        illegal_move = 0;
        if (hon && !rej) begin
            mb[pos] = side ? 2 : 1;
            w = winner();
            win = (w != 0);
            who = w[1:0];
            no_space = full();
            @(negedge clk);
            @(posedge clk); #1;
            win = 0;
            who = 0;
            no_space = 0;
            if (w != 0) begin
                mres  = w;
                mover = 1;
                if (w == 1 && ps < SMAX) ps++;
                if (w == 2 && cs < SMAX) cs++;
            end else if (full()) begin
                mres  = 3;
                mover = 1;
                if (dc < SMAX) dc++;
            end else begin
                mturn = !mturn;
            end
        end
        @(negedge clk);
        check_state("mv");
        @(posedge clk); #1;
    endtask

    task automatic play_list(input int seq[$]);
        foreach (seq[i]) move(i % 2 == 1, seq[i]);
    endtask

    initial begin
        int found;
        int steps;
        int r;
        int pos;
        bit side;
        bit last_wrong;
        int empt[$];

        reset = 1;
        start = 0;
        plyr_req = 0;
        plyr_pos = 0;
        comp_req = 0;
        comp_pos = 0;
        illegal_move = 0;
        win = 0;
        who = 0;
        no_space = 0;
        mturn = 0;
        mover = 0;
        mres = 0;
        ps = 0;
        cs = 0;
        dc = 0;
        for (int i = 0; i < 9; i++) mb[i] = 0;

        #3;
        chk("rst_clr", board_clr, 0);
        chk("rst_en", {pl_en, pc_en}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_ack", {plyr_ack, comp_ack, move_rej}, 0);
        check_state("rst");
        @(posedge clk); #1;

        // game 1: computer request held during the player's turn
        start_game();
        comp_req = 1;
        comp_pos = 0;
        plyr_req = 1;
        plyr_pos = 4;
        @(negedge clk);
        chk("pend_early", {plyr_ack, comp_ack}, 0);
        @(negedge clk);
        chk("pend_pack", plyr_ack, 1);
        chk("pend_cack", comp_ack, 0);
        chk("pend_pl", pl_en, 9'h010);
        chk("pend_pc", pc_en, 0);
        chk("pend_rej", move_rej, 0);
        @(posedge clk); #1;
        plyr_req = 0;
        mb[4] = 1;
        found = 0;
        for (int i = 1; i <= 6 && found == 0; i++) begin
            @(negedge clk);
            if (comp_ack) begin
                found = i;
                chk("pend_pc_en", pc_en, 9'h001);
                chk("pend_turn", turn, 1);
            end
        end
        chk("pend_lat", found, 3);
        mb[0] = 2;
        @(posedge clk); #1;
        comp_req = 0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check_state("pend");
        @(posedge clk); #1;

        // start is ignored mid-game
        start = 1;
        @(negedge clk);
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("start_ign", board_clr, 0);
        @(posedge clk); #1;

        move(0, 9);
        move(0, 4);
        play_list('{1, 3, 2, 5, 6, 8, 7});

        // game 2: player wins on the top row
        start_game();
        play_list('{0, 3, 1, 4, 2});
        move(1, 5);
        move(0, 6);

        // game 3: full board with no line
        start_game();
        play_list('{0, 1, 2, 4, 3, 5, 7, 6, 8});

        // random games drive the scores into saturation
        for (int g = 0; g < 14; g++) begin
            start_game();
            steps = 0;
            last_wrong = 0;
            while (!mover && steps < 40) begin
                side = mturn;
                if (!last_wrong && $urandom % 6 == 0) side = !mturn;
                last_wrong = (side != mturn);
                r = $urandom % 10;
                empt.delete();
                for (int i = 0; i < 9; i++) if (mb[i] == 0) empt.push_back(i);
                if (r == 0) pos = 9 + $urandom % 7;
                else if (r < 3 || empt.size() == 0) pos = $urandom % 9;
                else pos = empt[$urandom % empt.size()];
                move(side, pos);
                steps++;
            end
            move($urandom % 2 == 1, $urandom % 9);
        end

        // reset with a computer request in flight
        start_game();
        move(0, 4);
        comp_req = 1;
        comp_pos = 0;
        @(negedge clk);
        reset = 1;
        #1;
        chk("mrst_ack", comp_ack, 0);
        chk("mrst_pc", pc_en, 0);
        ps = 0;
        cs = 0;
        dc = 0;
        mres = 0;
        mturn = 0;
        mover = 0;
        check_state("mrst");
        comp_req = 0;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("mrst_ack2", comp_ack, 0);
        check_state("mrst2");
        @(posedge clk); #1;

`ifdef TTT_TIMEOUT_EN
        start_game();
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (timeout && found == 0) found = i;
            if (pl_en != 0) chk("tmo_pl", pl_en, 0);
        end
        chk("tmo_cyc", found, 10);
        mturn = 1;
        check_state("tmo");
        @(posedge clk); #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ttt_turn_scheduler.md
Name: ttt_turn_scheduler

Overview:
- Turn sequencer and write arbiter for the tic-tac-toe board datapath: position registers, illegal-move detector, winner detector and no-space detector.
- Accepts move requests from the human-player and computer sources over req/ack handshakes, and enforces strict alternation.
- Issues single-cycle write enables to the board and checks the post-move board for win or draw.
- Tracks a match score across games; sits between the board datapath and the move sources in place of the simple play/pc control.

Parameters:
- FIRST_MOVER, 0, side that moves first in every game: 0 = player, 1 = computer.
- SCORE_W, 4, width of each score counter.
- TIMEOUT_CYC, 1000, player move timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a new game from IDLE or OVER.
- plyr_req  in  1  player move request; held with plyr_pos until plyr_ack.
- plyr_pos  in  4  player cell index (0-8 legal).
- plyr_ack  out  1  one-cycle acknowledge to player.
- comp_req  in  1  computer move request; held with comp_pos until comp_ack.
- comp_pos  in  4  computer cell index.
- comp_ack  out  1  one-cycle acknowledge to computer.
- move_rej  out  1  qualifies ack: 1 = move rejected.
- illegal_move  in  1  from illegal-move detector, valid in the write cycle.
- win  in  1  from winner detector.
- who  in  2  winner code from winner detector: 01 = player, 10 = computer.
- no_space  in  1  from no-space detector.
- board_clr  out  1  one-cycle clear pulse to the position registers.
- pl_en  out  9  one-hot player write enable.
- pc_en  out  9  one-hot computer write enable.
- turn  out  1  current side to move: 0 = player, 1 = computer.
- game_over  out  1  high in OVER.
- result  out  2  last game outcome: 00 = none, 01 = player, 10 = computer, 11 = draw.
- plyr_score  out  SCORE_W  player wins.
- comp_score  out  SCORE_W  computer wins.
- draw_cnt  out  SCORE_W  number of draws.

Behaviour:
- Reset values: state IDLE; all enables, acks, move_rej and board_clr 0; game_over 0; result 00; all scores 0; turn = FIRST_MOVER.
- States: IDLE, CLEAR, WAIT, COMMIT, CHECK, OVER.
- IDLE: start=1 -> CLEAR.
- CLEAR:
  - board_clr=1 for exactly 1 cycle; result <= 00; turn <= FIRST_MOVER.
  - -> WAIT.
- WAIT:
  - Only the req of the side equal to turn is honoured; the other side's req is ignored and stays pending, never acked.
  - On honoured req -> COMMIT. The state captures the side; position is taken from that side's pos port, which is stable until ack.
- COMMIT (1 cycle):
  - Asserts ack for that side.
  - If pos > 8: move_rej=1, no enable asserted.
  - Otherwise the one-hot bit pos of pl_en/pc_en is asserted, and move_rej = illegal_move sampled this cycle.
  - Rejected move -> WAIT, same turn.
  - Accepted move -> CHECK.
- CHECK (1 cycle, board already updated): evaluated in this priority order.
  - win=1: result <= who; increment the matching score; -> OVER.
  - Else no_space=1: result <= 11; draw_cnt++; -> OVER.
  - Else turn flips; -> WAIT.
- Move latency: req seen at edge N -> enable and ack in cycle N+1 -> win/draw visible in result at N+3.
- OVER: game_over=1; all reqs ignored; start -> CLEAR. Scores persist across games.
- Scores saturate at 2^SCORE_W - 1; no wrap.
- start outside IDLE/OVER: ignored.
- Reset mid-game: immediate return to IDLE; scores cleared; any req in flight is dropped without ack.
- At most one bit set across pl_en|pc_en in any cycle.

Optional Feature:
- Macro: TTT_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT while turn=0 and restarts on every entry to WAIT.
  - At TIMEOUT_CYC cycles with no plyr_req, the player forfeits the turn: turn flips to 1, state stays WAIT, no board write.
  - An additional output timeout pulses high for 1 cycle at the forfeit.
- Undefined: no counter, no timeout port; WAIT holds indefinitely.

Test Plan:
- Reset, start, FIRST_MOVER=0, player req pos 4 -> board_clr one cycle, then pl_en=9'h010 and plyr_ack for 1 cycle, move_rej=0, turn=1 after CHECK.
- Computer req during player turn with comp_pos=0 -> no comp_ack and no pc_en until player move accepted; then pc_en=9'h001.
- Player req pos 9 -> plyr_ack with move_rej=1, pl_en=0, turn stays 0. Player req pos 4 with illegal_move=1 -> rejected, board unchanged.
- Player moves 0,1,2 interleaved with computer 3,4 and win/who=01 at the final CHECK -> result=01, plyr_score=1, game_over=1; a further req gets no ack.
- Nine accepted moves with no_space=1 at the last CHECK -> result=11, draw_cnt=1; then start -> board_clr pulse, result=00, scores retained.
- With TTT_TIMEOUT_EN and TIMEOUT_CYC=10, no plyr_req for 10 cycles in WAIT -> timeout pulse, turn=1, pl_en never asserted. Assert reset mid-WAIT -> IDLE, scores 0.
